brightness_contrast: RTL and testbench
======================================

BRIGHTNESS_CONTRAST -- requirements
Module: brightness_contrast

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 8, bits per channel sample (8..12).
REQ-002 SHALL have parameter CH_COUNT, default 3, channels per pixel (1..4); channel k at di_i[PIXEL_WIDTH*k +: PIXEL_WIDTH].
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  sole clock.
- rst  in  1  synchronous active-high reset.
- contrast_i  in  9*CH_COUNT  per-channel contrast, unsigned Q3.6; 64 = 1.0.
- brightness_i  in  (PIXEL_WIDTH+1)*CH_COUNT  per-channel brightness, signed two's complement.
- bypass_i  in  1  pass pixels unmodified.
- di_i  in  PIXEL_WIDTH*CH_COUNT  input pixel.
- de_i / hs_i / vs_i  in  1 each  video syncs; vs active-high.
- do_o  out  PIXEL_WIDTH*CH_COUNT  output pixel.
- de_o / hs_o / vs_o  out  1 each  delayed syncs.
- clip_lo_cnt_o / clip_hi_cnt_o  out  24 each  per-frame clip statistics.

Function
REQ-004 SHALL compute per channel, with mid = 2^(PIXEL_WIDTH-1): y = floor((c*(x-mid)+32)/64) + mid + b, clamped to [0, 2^PIXEL_WIDTH-1].
REQ-005 SHALL round half toward +infinity.
REQ-006 SHALL size internal arithmetic so no intermediate wraps for any legal c, x, b.
REQ-007 SHALL have a fixed latency of 5 clk from di_i/de_i/hs_i/vs_i to do_o/de_o/hs_o/vs_o, independent of de_i and bypass.
REQ-008 SHALL hold an active coefficient set (contrast, brightness, bypass) separate from the inputs.
REQ-009 SHALL load the active set from the inputs on the vs_i rising edge: the cycle with vs_i=1 after a registered vs_i=0.
REQ-010 SHALL process pixels sampled in the edge cycle with the old set, and pixels from the next cycle with the new set.
REQ-011 SHALL ignore input coefficient changes between vs edges.
REQ-012 SHALL, when active bypass=1, make do_o equal di_i delayed 5 clk.
REQ-013 SHALL process do_o every cycle regardless of de; de only qualifies the data.

Reset
REQ-014 SHALL, while rst=1, drive do_o, de_o, hs_o, vs_o, clip counters and all pipeline stages to 0.
REQ-015 SHALL reset the active set to contrast 64, brightness 0, bypass 0, and the vs edge detector to 0.
REQ-016 SHALL, after reset mid-frame, emit no stale pixels; the first output de_o=1 appears 5 clk after the first post-reset de_i=1.

Configuration
REQ-017 SHALL provide macro BRIGHTNESS_CLIP_STAT_EN.
REQ-018 SHALL, with the macro defined, count output pixels with de_o=1 where any channel clamped at 0 (lo) or at max (hi).
REQ-019 SHALL count a pixel in both counters if different channels clip each way.
REQ-020 SHALL saturate both counts at 2^24-1.
REQ-021 SHALL, on the vs_o rising edge, copy the counts to clip_*_cnt_o and restart counting; a pixel in the edge cycle counts toward the new frame.
REQ-022 SHALL, without the macro, keep the clip ports and drive them constant 0, with no counter logic.

Structure
REQ-023 SHALL place the Q3.6 constants (coefficient width 9, fraction 6, unity 64, rounding 32), the latency constant 5 and the stat width 24 in shared package video_filter_pkg.
REQ-024 SHALL instantiate one sub-module per channel, bc_channel, implementing the REQ-004 datapath and emitting per-channel clip_lo/clip_hi flags.
REQ-025 SHALL keep sync delay, coefficient shadowing and statistics in the top level.

Verification (PIXEL_WIDTH=8, CH_COUNT=3)
REQ-026 SHALL cover: c=64, b=0, pixel (10,128,250) -> do_o (10,128,250) exactly 5 clk later, de/hs/vs aligned.
REQ-027 SHALL cover: c=128, b=0, x=200/50/129 -> 255/0/130; with c=96, x=129/127 -> 130/127.
REQ-028 SHALL cover: c=64, b=-20, x=15/100 -> 0/80; b=+200, x=100 -> 255.
REQ-029 SHALL cover: change c mid-frame from 64 to 128 -> output unchanged until the vs_i edge; the edge-cycle pixel uses 64, the next pixel uses 128.
REQ-030 SHALL cover: rst pulsed 1 clk mid-line -> outputs 0, active set back to 1.0/0; no de_o until 5 clk after the next de_i.
REQ-031 SHALL cover (macro defined): frame of 10 pixels, 3 clipped high and 2 low -> clip_hi_cnt_o=3, clip_lo_cnt_o=2 after the next vs_o edge; without the macro both stay 0.

Source files
------------

// File: rtl/video_filter_pkg.sv
// Shared constants for the video filter blocks: Q3.6 coefficient format,
// pipeline latency and clip-statistic counter width.
package video_filter_pkg;

   localparam int COEF_W     = 9;
   localparam int COEF_FRAC  = 6;
   localparam int COEF_UNITY = 64;
   localparam int COEF_ROUND = 32;
   localparam int LATENCY    = 5;
   localparam int STAT_W     = 24;

endpackage

// File: rtl/bc_channel.sv
// Single-channel brightness/contrast datapath, five register stages:
// centre, multiply, round+shift, offset, clamp. Emits registered clip flags.
module bc_channel
   import video_filter_pkg::*;
#(
   parameter int PIXEL_WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [COEF_W-1:0]        contrast,
   input  logic signed [PIXEL_WIDTH:0] brightness,
   input  logic                     bypass,
   input  logic [PIXEL_WIDTH-1:0]   din,
   output logic [PIXEL_WIDTH-1:0]   dout,
   output logic                     clip_lo,
   output logic                     clip_hi
);

   // Wide enough for c*(x-mid) plus rounding, offset and brightness without wrap.
   localparam int AW = PIXEL_WIDTH + COEF_W + 3;
   localparam logic signed [AW-1:0] MID  = AW'(2 ** (PIXEL_WIDTH - 1));
   localparam logic signed [AW-1:0] MAXV = AW'(2 ** PIXEL_WIDTH - 1);
   localparam logic signed [AW-1:0] RND  = AW'(COEF_ROUND);
   localparam logic signed [PIXEL_WIDTH:0] MID_N = {2'b01, {(PIXEL_WIDTH-1){1'b0}}};

   logic signed [PIXEL_WIDTH:0]   xc1;
   logic [COEF_W-1:0]             c1;
   logic signed [PIXEL_WIDTH:0]   b1, b2, b3, b4;
   logic                          byp1, byp2, byp3, byp4;
   logic [PIXEL_WIDTH-1:0]        raw1, raw2, raw3, raw4;
   logic signed [AW-1:0]          prod2, sh3, sum4;
   logic signed [AW-1:0]          c_ext, x_ext, b_ext;

   assign c_ext = {{(AW-COEF_W){1'b0}}, c1};
   assign x_ext = {{(AW-PIXEL_WIDTH-1){xc1[PIXEL_WIDTH]}}, xc1};
   assign b_ext = {{(AW-PIXEL_WIDTH-1){b3[PIXEL_WIDTH]}}, b3};

   always_ff @(posedge clk) begin
      if (rst) begin
         xc1 <= '0;  c1 <= '0;  b1 <= '0;  byp1 <= 1'b0; raw1 <= '0;
         prod2 <= '0; b2 <= '0; byp2 <= 1'b0; raw2 <= '0;
         sh3 <= '0;  b3 <= '0;  byp3 <= 1'b0; raw3 <= '0;
         sum4 <= '0; b4 <= '0;  byp4 <= 1'b0; raw4 <= '0;
         dout <= '0; clip_lo <= 1'b0; clip_hi <= 1'b0;
      end else begin
         xc1  <= $signed({1'b0, din}) - MID_N;
         c1   <= contrast;
         b1   <= brightness;
         byp1 <= bypass;
         raw1 <= din;

         prod2 <= c_ext * x_ext;
         b2    <= b1;
         byp2  <= byp1;
         raw2  <= raw1;

         // Arithmetic shift of (p + 32) gives floor, i.e. round half up.
         sh3  <= (prod2 + RND) >>> COEF_FRAC;
         b3   <= b2;
         byp3 <= byp2;
         raw3 <= raw2;

         sum4 <= sh3 + MID + b_ext;
         b4   <= b3;
         byp4 <= byp3;
         raw4 <= raw3;

         clip_lo <= 1'b0;
         clip_hi <= 1'b0;
         if (byp4) begin
            dout <= raw4;
         end else if (sum4 < 0) begin
            dout    <= '0;
            clip_lo <= 1'b1;
         end else if (sum4 > MAXV) begin
            dout    <= '1;
            clip_hi <= 1'b1;
         end else begin
            dout <= sum4[PIXEL_WIDTH-1:0];
         end
      end
   end

   // b4 only keeps stage alignment readable; it has no consumer.
   logic unused_b4;
   assign unused_b4 = ^b4;

endmodule

// File: rtl/brightness_contrast.sv
// Brightness/contrast top: per-channel datapaths, sync delay, coefficient
// shadowing on vs rising edge. Clip statistics enabled by BRIGHTNESS_CLIP_STAT_EN.
module brightness_contrast
   import video_filter_pkg::*;
#(
   parameter int PIXEL_WIDTH = 8,
   parameter int CH_COUNT    = 3
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [COEF_W*CH_COUNT-1:0]        contrast_i,
   input  logic [(PIXEL_WIDTH+1)*CH_COUNT-1:0] brightness_i,
   input  logic                              bypass_i,
   input  logic [PIXEL_WIDTH*CH_COUNT-1:0]   di_i,
   input  logic                              de_i,
   input  logic                              hs_i,
   input  logic                              vs_i,
   output logic [PIXEL_WIDTH*CH_COUNT-1:0]   do_o,
   output logic                              de_o,
   output logic                              hs_o,
   output logic                              vs_o,
   output logic [STAT_W-1:0]                 clip_lo_cnt_o,
   output logic [STAT_W-1:0]                 clip_hi_cnt_o
);

   localparam logic [COEF_W-1:0] UNITY = COEF_W'(COEF_UNITY);

   logic                                 vs_q;
   logic                                 vs_edge;
   logic [COEF_W*CH_COUNT-1:0]           act_c;
   logic [(PIXEL_WIDTH+1)*CH_COUNT-1:0]  act_b;
   logic                                 act_byp;
   logic [LATENCY-1:0]                   de_d, hs_d, vs_d;
   logic [CH_COUNT-1:0]                  clip_lo_ch, clip_hi_ch;

   assign vs_edge = vs_i & ~vs_q;

   // New set becomes visible the cycle after the edge, so the edge pixel uses the old one.
   always_ff @(posedge clk) begin
      if (rst) begin
         vs_q    <= 1'b0;
         act_c   <= {CH_COUNT{UNITY}};
         act_b   <= '0;
         act_byp <= 1'b0;
         de_d    <= '0;
         hs_d    <= '0;
         vs_d    <= '0;
      end else begin
         vs_q <= vs_i;
         if (vs_edge) begin
            act_c   <= contrast_i;
            act_b   <= brightness_i;
            act_byp <= bypass_i;
         end
         de_d <= {de_d[LATENCY-2:0], de_i};
         hs_d <= {hs_d[LATENCY-2:0], hs_i};
         vs_d <= {vs_d[LATENCY-2:0], vs_i};
      end
   end

   assign de_o = de_d[LATENCY-1];
   assign hs_o = hs_d[LATENCY-1];
   assign vs_o = vs_d[LATENCY-1];

   for (genvar k = 0; k < CH_COUNT; k++) begin : g_ch
      bc_channel #(.PIXEL_WIDTH(PIXEL_WIDTH)) u_ch (
         .clk        (clk),
         .rst        (rst),
         .contrast   (act_c[COEF_W*k +: COEF_W]),
         .brightness (act_b[(PIXEL_WIDTH+1)*k +: (PIXEL_WIDTH+1)]),
         .bypass     (act_byp),
         .din        (di_i[PIXEL_WIDTH*k +: PIXEL_WIDTH]),
         .dout       (do_o[PIXEL_WIDTH*k +: PIXEL_WIDTH]),
         .clip_lo    (clip_lo_ch[k]),
         .clip_hi    (clip_hi_ch[k])
      );
   end

`ifdef BRIGHTNESS_CLIP_STAT_EN
   logic              vs_o_q;
   logic              lo_inc, hi_inc;
   logic [STAT_W-1:0] lo_cnt, hi_cnt;

   assign lo_inc = de_o & (|clip_lo_ch);
   assign hi_inc = de_o & (|clip_hi_ch);

   // The edge-cycle pixel seeds the new frame's count.
   always_ff @(posedge clk) begin
      if (rst) begin
         vs_o_q        <= 1'b0;
         lo_cnt        <= '0;
         hi_cnt        <= '0;
         clip_lo_cnt_o <= '0;
         clip_hi_cnt_o <= '0;
      end else begin
         vs_o_q <= vs_o;
         if (vs_o & ~vs_o_q) begin
            clip_lo_cnt_o <= lo_cnt;
            clip_hi_cnt_o <= hi_cnt;
            lo_cnt        <= STAT_W'(lo_inc);
            hi_cnt        <= STAT_W'(hi_inc);
         end else begin
            if (lo_inc && lo_cnt != '1) lo_cnt <= lo_cnt + 1'b1;
            if (hi_inc && hi_cnt != '1) hi_cnt <= hi_cnt + 1'b1;
         end
      end
   end
`else
   logic unused_clip;
   assign unused_clip   = ^{clip_lo_ch, clip_hi_ch};
   assign clip_lo_cnt_o = '0;
   assign clip_hi_cnt_o = '0;
`endif

endmodule

// File: tb/tb_brightness_contrast.sv
// Directed bench for brightness_contrast (8-bit, 3 channels); clip-count
// expectations follow BRIGHTNESS_CLIP_STAT_EN.
module tb_brightness_contrast;

   logic        clk;
   logic        rst;
   logic [26:0] contrast_i;
   logic [26:0] brightness_i;
   logic        bypass_i;
   logic [23:0] di_i;
   logic        de_i, hs_i, vs_i;
   logic [23:0] do_o;
   logic        de_o, hs_o, vs_o;
   logic [23:0] clip_lo_cnt_o, clip_hi_cnt_o;

   int n_chk  = 0;
   int n_pass = 0;

   brightness_contrast #(.PIXEL_WIDTH(8), .CH_COUNT(3)) dut (
      .clk           (clk),
      .rst           (rst),
      .contrast_i    (contrast_i),
      .brightness_i  (brightness_i),
      .bypass_i      (bypass_i),
      .di_i          (di_i),
      .de_i          (de_i),
      .hs_i          (hs_i),
      .vs_i          (vs_i),
      .do_o          (do_o),
      .de_o          (de_o),
      .hs_o          (hs_o),
      .vs_o          (vs_o),
      .clip_lo_cnt_o (clip_lo_cnt_o),
      .clip_hi_cnt_o (clip_hi_cnt_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      else
         n_pass++;
   endtask

   function automatic logic [23:0] px(input logic [7:0] c0, input logic [7:0] c1,
                                      input logic [7:0] c2);
      return {c2, c1, c0};
   endfunction

   // One pixel with de/hs high, then idle; samples de_o one cycle early and output at +5.
   task automatic send_px(input logic [23:0] p, output logic pre_de, output logic [23:0] q,
                          output logic q_de, output logic q_hs);
      di_i = p; de_i = 1'b1; hs_i = 1'b1;
      @(posedge clk); #1;
      de_i = 1'b0; hs_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      pre_de = de_o;
      @(posedge clk); #1;
      q    = do_o;
      q_de = de_o;
      q_hs = hs_o;
   endtask

   task automatic load_coef(input logic [26:0] c, input logic [26:0] b, input logic byp);
      contrast_i = c; brightness_i = b; bypass_i = byp;
      vs_i = 1'b1;
      @(posedge clk); #1;
      vs_i = 1'b0;
      @(posedge clk); #1;
   endtask

   localparam logic [26:0] C64  = {3{9'd64}};
   localparam logic [26:0] C96  = {3{9'd96}};
   localparam logic [26:0] C128 = {3{9'd128}};

   initial begin
      logic        pre_de, q_de, q_hs;
      logic [23:0] q, q2;
      logic        stale;
      logic [23:0] exp_hi, exp_lo;
      logic [23:0] frame [10];

      rst = 1'b1; contrast_i = C128; brightness_i = '0; bypass_i = 1'b0;
      di_i = px(8'd1, 8'd2, 8'd3); de_i = 1'b1; hs_i = 1'b1; vs_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_do", do_o, 0);
      check("rst_de", {hs_o, vs_o, de_o}, 0);
      check("rst_lo", clip_lo_cnt_o, 0);
      check("rst_hi", clip_hi_cnt_o, 0);
      rst = 1'b0; de_i = 1'b0; hs_i = 1'b0; di_i = '0;
      repeat (6) @(posedge clk);
      #1;

      // Reset default set is identity even though contrast_i already shows 128.
      send_px(px(8'd10, 8'd128, 8'd250), pre_de, q, q_de, q_hs);
      check("ident_pre_de", pre_de, 0);
      check("ident_do", q, px(8'd10, 8'd128, 8'd250));
      check("ident_de", q_de, 1);
      check("ident_hs", q_hs, 1);

      load_coef(C128, '0, 1'b0);
      send_px(px(8'd200, 8'd50, 8'd129), pre_de, q, q_de, q_hs);
      check("c128_do", q, px(8'd255, 8'd0, 8'd130));

      load_coef(C96, '0, 1'b0);
      send_px(px(8'd129, 8'd127, 8'd128), pre_de, q, q_de, q_hs);
      check("c96_do", q, px(8'd130, 8'd127, 8'd128));

      load_coef(C64, {9'd200, 9'h1EC, 9'h1EC}, 1'b0);
      send_px(px(8'd15, 8'd100, 8'd100), pre_de, q, q_de, q_hs);
      check("bright_do", q, px(8'd0, 8'd80, 8'd255));

      load_coef(C128, '0, 1'b1);
      send_px(px(8'd200, 8'd50, 8'd129), pre_de, q, q_de, q_hs);
      check("bypass_do", q, px(8'd200, 8'd50, 8'd129));

      // Mid-frame coefficient change is ignored until the vs edge.
      load_coef(C64, '0, 1'b0);
      contrast_i = C128;
      send_px(px(8'd200, 8'd50, 8'd129), pre_de, q, q_de, q_hs);
      check("midframe_do", q, px(8'd200, 8'd50, 8'd129));

      di_i = px(8'd200, 8'd50, 8'd129); de_i = 1'b1; vs_i = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      de_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("edge_old_do", do_o, px(8'd200, 8'd50, 8'd129));
      check("edge_vs", {vs_o, de_o}, 2'b11);
      @(posedge clk); #1;
      check("edge_new_do", do_o, px(8'd255, 8'd0, 8'd130));
      vs_i = 1'b0;
      repeat (6) @(posedge clk);
      #1;

      // Reset mid-line: pipeline flushed and active set back to identity.
      di_i = px(8'd200, 8'd50, 8'd129); de_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_do", do_o, 0);
      check("midrst_de", de_o, 0);
      rst = 1'b0; de_i = 1'b0; di_i = '0;
      stale = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         stale = stale | de_o;
      end
      check("midrst_stale", stale, 0);
      send_px(px(8'd200, 8'd50, 8'd129), pre_de, q, q_de, q_hs);
      check("midrst_pre_de", pre_de, 0);
      check("midrst_ident", {q_de, q}, {1'b1, px(8'd200, 8'd50, 8'd129)});

      // Clip frame: one pixel clips both ways, two more high, one more low.
      frame[0] = px(8'd200, 8'd50, 8'd128);
      frame[1] = px(8'd128, 8'd128, 8'd128);
      frame[2] = px(8'd200, 8'd128, 8'd128);
      frame[3] = px(8'd128, 8'd130, 8'd128);
      frame[4] = px(8'd128, 8'd128, 8'd50);
      frame[5] = px(8'd129, 8'd127, 8'd128);
      frame[6] = px(8'd128, 8'd200, 8'd128);
      frame[7] = px(8'd150, 8'd100, 8'd128);
      frame[8] = px(8'd128, 8'd128, 8'd128);
      frame[9] = px(8'd128, 8'd128, 8'd191);
      load_coef(C128, '0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         di_i = frame[i]; de_i = 1'b1;
         @(posedge clk); #1;
      end
      de_i = 1'b0; di_i = px(8'd128, 8'd128, 8'd128);
      q2 = '0;
      repeat (2) @(posedge clk);
      #1;
      load_coef(C128, '0, 1'b0);
      repeat (8) @(posedge clk);
      #1;
`ifdef BRIGHTNESS_CLIP_STAT_EN
      exp_hi = 24'd3;
      exp_lo = 24'd2;
`else
      exp_hi = 24'd0;
      exp_lo = 24'd0;
`endif
      check("clip_hi_cnt", clip_hi_cnt_o + q2, exp_hi);
      check("clip_lo_cnt", clip_lo_cnt_o, exp_lo);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
